// File: rtl/control_chain_sequencer.sv
// Sequences the per-sample flight-control stage chain and owns the motor-enable gate.
// Each stage gets a start pulse and a bounded time to answer; faults and stale frames drop the gate.
module control_chain_sequencer #(
    parameter int NUM_STAGES    = 4,
    parameter int STAGE_TIMEOUT = 38000,
    parameter int FRAME_TIMEOUT = 760000,
    parameter int OVR_WIDTH     = 8
) (
    input  logic                          sys_clk,
    input  logic                          resetn,
    input  logic                          imu_good,
    input  logic                          imu_valid_strobe,
    input  logic [NUM_STAGES-1:0]         stage_complete,
    input  logic                          clear_fault,
    output logic [NUM_STAGES-1:0]         stage_start,
    output logic                          frame_done,
    output logic                          busy,
    output logic                          motor_enable,
    output logic                          fault,
    output logic [$clog2(NUM_STAGES)-1:0] fault_stage,
    output logic [OVR_WIDTH-1:0]          overrun_count
);
    localparam int IDX_W = $clog2(NUM_STAGES);
    localparam int ST_W  = $clog2(STAGE_TIMEOUT + 1);
    localparam int FT_W  = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_STAGES - 1);
    // Limits are one below the timeout so the flag lands exactly TIMEOUT cycles after the start.
    localparam logic [ST_W-1:0]       ST_LIMIT = ST_W'(STAGE_TIMEOUT - 1);
    localparam logic [FT_W-1:0]       FT_LIMIT = FT_W'(FRAME_TIMEOUT - 1);
    localparam logic [OVR_WIDTH-1:0]  OVR_MAX  = {OVR_WIDTH{1'b1}};
    localparam logic [NUM_STAGES-1:0] START0   = {{(NUM_STAGES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      stage_idx_q, stage_idx_d, stage_idx_nxt_s;
    logic [ST_W-1:0]       stage_timer_q, stage_timer_d;
    logic [FT_W-1:0]       frame_timer_q, frame_timer_d;
    logic [NUM_STAGES-1:0] stage_start_q, stage_start_d;
    logic                  frame_done_q, frame_done_d;
    logic                  busy_q, busy_d;
    logic                  motor_enable_q, motor_enable_d;
    logic                  fault_q, fault_d;
    logic [IDX_W-1:0]      fault_stage_q, fault_stage_d;
    logic [OVR_WIDTH-1:0]  overrun_q, overrun_d;

    assign stage_idx_nxt_s = stage_idx_q + IDX_W'(1'b1);

    // Next-state, timer and output computation for the sequencer.
    always_comb begin
        state_d        = state_q;
        stage_idx_d    = stage_idx_q;
        stage_timer_d  = stage_timer_q;
        frame_timer_d  = frame_timer_q;
        stage_start_d  = '0;
        frame_done_d   = 1'b0;
        busy_d         = busy_q;
        motor_enable_d = motor_enable_q;
        fault_d        = fault_q;
        fault_stage_d  = fault_stage_q;
        overrun_d      = overrun_q;

        // Frame watchdog; the state logic below overrides it on frame_done or abort.
        if (motor_enable_q) begin
            if (frame_timer_q >= FT_LIMIT) begin
                motor_enable_d = 1'b0;
                frame_timer_d  = '0;
            end else begin
                frame_timer_d  = frame_timer_q + FT_W'(1'b1);
            end
        end else begin
            frame_timer_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (imu_valid_strobe && imu_good) begin
                    state_d       = ST_RUN;
                    stage_idx_d   = '0;
                    stage_timer_d = '0;
                    stage_start_d = START0;
                    busy_d        = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (imu_valid_strobe && (overrun_q != OVR_MAX)) begin
                    overrun_d = overrun_q + OVR_WIDTH'(1'b1);
                end else begin
                    overrun_d = overrun_q;
                end
                if (!imu_good) begin
                    state_d        = ST_IDLE;
                    busy_d         = 1'b0;
                    motor_enable_d = 1'b0;
                    frame_timer_d  = '0;
                end else if (stage_complete[stage_idx_q]) begin
                    if (stage_idx_q == LAST_IDX) begin
                        state_d        = ST_IDLE;
                        frame_done_d   = 1'b1;
                        motor_enable_d = 1'b1;
                        busy_d         = 1'b0;
                        frame_timer_d  = '0;
                    end else begin
                        stage_idx_d   = stage_idx_nxt_s;
                        stage_timer_d = '0;
                        stage_start_d = START0 << stage_idx_nxt_s;
                    end
                end else if (stage_timer_q >= ST_LIMIT) begin
                    state_d        = ST_FAULT;
                    fault_d        = 1'b1;
                    fault_stage_d  = stage_idx_q;
                    motor_enable_d = 1'b0;
                    busy_d         = 1'b0;
                    frame_timer_d  = '0;
                end else begin
                    stage_timer_d = stage_timer_q + ST_W'(1'b1);
                end
            end
            ST_FAULT: begin
                motor_enable_d = 1'b0;
                frame_timer_d  = '0;
                if (clear_fault) begin
                    state_d       = ST_IDLE;
                    fault_d       = 1'b0;
                    fault_stage_d = '0;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                busy_d         = 1'b0;
                motor_enable_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            stage_idx_q    <= '0;
            stage_timer_q  <= '0;
            frame_timer_q  <= '0;
            stage_start_q  <= '0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
            motor_enable_q <= 1'b0;
            fault_q        <= 1'b0;
            fault_stage_q  <= '0;
            overrun_q      <= '0;
        end else begin
            state_q        <= state_d;
            stage_idx_q    <= stage_idx_d;
            stage_timer_q  <= stage_timer_d;
            frame_timer_q  <= frame_timer_d;
            stage_start_q  <= stage_start_d;
            frame_done_q   <= frame_done_d;
            busy_q         <= busy_d;
            motor_enable_q <= motor_enable_d;
            fault_q        <= fault_d;
            fault_stage_q  <= fault_stage_d;
            overrun_q      <= overrun_d;
        end
    end

    assign stage_start   = stage_start_q;
    assign frame_done    = frame_done_q;
    assign busy          = busy_q;
    assign motor_enable  = motor_enable_q;
    assign fault         = fault_q;
    assign fault_stage   = fault_stage_q;
    assign overrun_count = overrun_q;

endmodule

// File: doc/control_chain_sequencer.md
Name: control_chain_sequencer

Overview:
- Sequences the flight-control chain once per IMU sample: throttle controller → yaw angle accumulator → angle controller → body frame controller.
- Issues a one-cycle start strobe to each stage, waits for that stage's complete strobe, and enforces a per-stage timeout.
- Owns the motor-enable gate consumed by the motor mixer and PWM generator, and drops it on any sequencing fault or when control frames go stale.
- Sits between bno055_driver and the control stages, replacing the hard-wired strobe chain.

Parameters:
- NUM_STAGES, 4, number of chained stages (minimum 2).
- STAGE_TIMEOUT, 38000, sys_clk cycles allowed per stage (1 ms at 38 MHz).
- FRAME_TIMEOUT, 760000, max sys_clk cycles between frame_done pulses while motors are enabled (20 ms).
- OVR_WIDTH, 8, width of the overrun counter.

Ports:
- sys_clk  in  1  system clock, 38 MHz.
- resetn  in  1  reset, synchronous, active-low.
- imu_good  in  1  IMU initialised and streaming.
- imu_valid_strobe  in  1  one-cycle new-sample pulse.
- stage_complete  in  NUM_STAGES  per-stage one-cycle done pulses.
- clear_fault  in  1  one-cycle fault acknowledge.
- stage_start  out  NUM_STAGES  per-stage one-cycle start pulses.
- frame_done  out  1  one-cycle pulse after the last stage completes.
- busy  out  1  high while a frame is in progress.
- motor_enable  out  1  gate for motor outputs.
- fault  out  1  sticky stage-timeout flag.
- fault_stage  out  $clog2(NUM_STAGES)  index of the stage that timed out.
- overrun_count  out  OVR_WIDTH  saturating count of dropped IMU strobes.

Behaviour:
- All outputs are registered. Reset values:
  - stage_start = 0, frame_done = 0, busy = 0, motor_enable = 0, fault = 0, fault_stage = 0, overrun_count = 0.
  - State = IDLE; stage index and both timers = 0.
- States: IDLE, RUN, FAULT.
- IDLE:
  - imu_valid_strobe && imu_good → next cycle stage_start[0] = 1 for exactly 1 cycle, busy = 1, stage index = 0, stage timer cleared, go to RUN.
  - A strobe with imu_good = 0 is ignored.
- RUN, stage i:
  - The stage timer increments every cycle after stage_start[i].
  - stage_complete[i] = 1 and i < NUM_STAGES-1 → next cycle stage_start[i+1] pulses and the timer clears (1-cycle inter-stage latency).
  - stage_complete[NUM_STAGES-1] → next cycle frame_done pulses, motor_enable = 1, busy = 0, frame timer clears, go to IDLE.
  - stage_complete bits for any stage other than i are ignored.
  - Stage timer reaches STAGE_TIMEOUT without stage_complete[i] → go to FAULT; fault = 1, fault_stage = i, motor_enable = 0, busy = 0, stage_start = 0.
  - If stage_complete[i] and timeout expiry occur in the same cycle, the completion wins.
  - imu_valid_strobe in RUN → strobe dropped; overrun_count increments, saturating at all-ones. The frame continues.
  - imu_good falling in RUN → abort to IDLE next cycle; busy = 0, motor_enable = 0, fault unchanged, no frame_done.
- Start-to-frame_done latency: minimum is NUM_STAGES + 1 cycles after the IMU strobe, plus the stage compute times.
- FAULT:
  - All strobes are ignored; motor_enable is held 0.
  - clear_fault → fault = 0, fault_stage = 0, go to IDLE.
  - clear_fault outside FAULT has no effect.
- Frame watchdog:
  - While motor_enable = 1, the frame timer counts cycles since the last frame_done.
  - Reaching FRAME_TIMEOUT → motor_enable = 0, with no state change and no fault.
  - The next frame_done re-enables motors.
- Timers saturate and never wrap.
- overrun_count clears only on reset.
- resetn low in any state, including mid-frame → all reset values on the next edge; any pending stage_start pulse is suppressed.

Test Plan:
- Nominal frame:
  - Stimulus: imu_good = 1; strobe at cycle 0; each stage completes 5 cycles after its start.
  - Required: stage_start[0..3] at cycles 1, 7, 13, 19; frame_done at cycle 25; motor_enable rises at cycle 25; busy high over cycles 1–24.
- Stage timeout:
  - Stimulus: stage 2 never completes; STAGE_TIMEOUT overridden to 100.
  - Required: fault = 1 and fault_stage = 2 at 100 cycles after stage_start[2]; motor_enable = 0; later strobes produce no stage_start.
  - Then clear_fault → IDLE; the next strobe runs a clean frame.
- Overrun:
  - Stimulus: 300 strobes arrive mid-frame across frames.
  - Required: overrun_count saturates at 255; the in-flight frame still completes normally.
- Boundary and ordering:
  - stage_complete[i] coincident with timeout expiry → next stage starts, no fault.
  - stage_complete[3] pulsed while in stage 1 → ignored.
  - imu_good dropped during stage 1 → IDLE, motor_enable = 0, no frame_done.
- Frame watchdog:
  - Stimulus: after one good frame, no further strobes; FRAME_TIMEOUT overridden to 500.
  - Required: motor_enable falls 500 cycles after frame_done; fault stays 0; the next good frame restores motor_enable.
- Reset mid-frame:
  - Stimulus: resetn low for 1 cycle during stage 2.
  - Required: all outputs at reset values on the next edge; stage 3 is never started.
